// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku input controller.
//   mode_t   : controller mode (cursor move, number preview, command issue)
//   KEY_*    : key indices in arbitration priority order (index 0 wins)
package sudoku_pkg;

  typedef enum logic [1:0] {
    MODE_MOVE   = 2'd0,
    MODE_NUMBER = 2'd1,
    MODE_ISSUE  = 2'd2
  } mode_t;

  localparam int unsigned KEY_C    = 0;
  localparam int unsigned KEY_U    = 1;
  localparam int unsigned KEY_D    = 2;
  localparam int unsigned KEY_L    = 3;
  localparam int unsigned KEY_R    = 4;
  localparam int unsigned NUM_KEYS = 5;

endpackage

// File: rtl/key_repeat.sv
// Edge detector with optional auto-repeat for one debounced key level.
// Ports:
//   i_clk     : system clock
//   i_reset_n : asynchronous active-low reset
//   i_clr     : synchronous clear of the pulse and repeat state
//   i_level   : debounced key level
//   o_pulse   : one-cycle pulse on press, then on each repeat while held
// REPEAT_DELAY = 0 disables repeat entirely (single pulse per press).
module key_repeat #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 15_000_000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_level,
  output logic o_pulse
);

  localparam bit          REPEAT_EN = (REPEAT_DELAY != 0);
  localparam int unsigned CNT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CNT_RATE  = CNT_W'(REPEAT_RATE);

  logic             r_level;
  logic             r_pulse;
  logic             r_first;
  logic [CNT_W-1:0] r_cnt;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_target;
  logic             w_pulse_nxt;
  logic             w_first_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_rise       = i_level & ~r_level;
  assign w_cnt_inc    = r_cnt + 1'b1;
  // First repeat waits the long delay, later ones use the rate.
  assign w_cnt_target = r_first ? CNT_DELAY : CNT_RATE;

  always_comb begin
    w_pulse_nxt = 1'b0;
    w_first_nxt = r_first;
    w_cnt_nxt   = r_cnt;
    if (i_clr) begin
      w_first_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else if (w_rise) begin
      w_pulse_nxt = 1'b1;
      w_first_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else if (!i_level) begin
      w_first_nxt = 1'b1;
      w_cnt_nxt   = '0;
    end else if (REPEAT_EN) begin
      if (w_cnt_inc == w_cnt_target) begin
        w_pulse_nxt = 1'b1;
        w_first_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_first <= 1'b1;
      r_cnt   <= '0;
    end else begin
      // Level keeps tracking through a clear so a held key does not re-fire.
      r_level <= i_level;
      r_pulse <= w_pulse_nxt;
      r_first <= w_first_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/sudoku_input_ctrl.sv
// Cursor and number-entry controller for an N x N Sudoku grid.
// Ports:
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_puzzle_change           : synchronous soft reset (wins over every key)
//   i_key_u/d/l/r/c           : debounced button levels
//   i_cell_fixed, i_cell_val  : fixed bit and value of the cell under the cursor
//   i_cmd_ready               : engine accepts the pending command
//   o_cursor_x, o_cursor_y    : cursor position
//   o_mode                    : MOVE / NUMBER / ISSUE
//   o_selected_number         : number being previewed in NUMBER mode
//   o_cmd_valid, o_cmd_x/y,
//   o_cmd_number              : write command (number 0 clears the cell)
//   o_fixed_deny              : one-cycle pulse when C hits a fixed cell
//   o_flash                   : cursor visibility for the draw module
module sudoku_input_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned GRID_N       = 9,
  parameter int unsigned COORD_W      = $clog2(GRID_N),
  parameter int unsigned VAL_W        = $clog2(GRID_N + 1),
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 15_000_000,
  parameter int unsigned FLASH_BITS   = 27
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_puzzle_change,
  input  logic               i_key_u,
  input  logic               i_key_d,
  input  logic               i_key_l,
  input  logic               i_key_r,
  input  logic               i_key_c,
  input  logic               i_cell_fixed,
  input  logic [VAL_W-1:0]   i_cell_val,
  input  logic               i_cmd_ready,
  output logic [COORD_W-1:0] o_cursor_x,
  output logic [COORD_W-1:0] o_cursor_y,
  output mode_t              o_mode,
  output logic [VAL_W-1:0]   o_selected_number,
  output logic               o_cmd_valid,
  output logic [COORD_W-1:0] o_cmd_x,
  output logic [COORD_W-1:0] o_cmd_y,
  output logic [VAL_W-1:0]   o_cmd_number,
  output logic               o_fixed_deny,
  output logic               o_flash
);

  localparam logic [COORD_W-1:0] COORD_LAST = COORD_W'(GRID_N - 1);
  localparam logic [VAL_W-1:0]   VAL_LAST   = VAL_W'(GRID_N);
  localparam logic [VAL_W-1:0]   VAL_ONE    = VAL_W'(1);

  // ---------------------------------------------------------------------------
  // Key pulse generation
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] w_key_level;
  logic [NUM_KEYS-1:0] w_key_pulse;

  assign w_key_level[KEY_C] = i_key_c;
  assign w_key_level[KEY_U] = i_key_u;
  assign w_key_level[KEY_D] = i_key_d;
  assign w_key_level[KEY_L] = i_key_l;
  assign w_key_level[KEY_R] = i_key_r;

  // C is a commit/enter key, so it never auto-repeats.
  key_repeat #(
    .REPEAT_DELAY (0),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_key_c (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (i_puzzle_change),
    .i_level   (w_key_level[KEY_C]),
    .o_pulse   (w_key_pulse[KEY_C])
  );

  for (genvar k = KEY_U; k <= KEY_R; k++) begin : g_dir_key
    key_repeat #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_key (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (i_puzzle_change),
      .i_level   (w_key_level[k]),
      .o_pulse   (w_key_pulse[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Wrapping arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic [COORD_W-1:0] coord_inc(input logic [COORD_W-1:0] c);
    return (c == COORD_LAST) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [COORD_W-1:0] coord_dec(input logic [COORD_W-1:0] c);
    return (c == '0) ? COORD_LAST : c - 1'b1;
  endfunction

  // Cell values live in 1..GRID_N; 0 is reserved for "empty".
  function automatic logic [VAL_W-1:0] val_inc(input logic [VAL_W-1:0] v);
    return (v == VAL_LAST) ? VAL_ONE : v + 1'b1;
  endfunction

  function automatic logic [VAL_W-1:0] val_dec(input logic [VAL_W-1:0] v);
    return (v <= VAL_ONE) ? VAL_LAST : v - 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0]    r_cursor_x,  w_cursor_x_nxt;
  logic [COORD_W-1:0]    r_cursor_y,  w_cursor_y_nxt;
  mode_t                 r_mode,      w_mode_nxt;
  logic [VAL_W-1:0]      r_sel,       w_sel_nxt;
  logic                  r_cmd_valid, w_cmd_valid_nxt;
  logic [COORD_W-1:0]    r_cmd_x,     w_cmd_x_nxt;
  logic [COORD_W-1:0]    r_cmd_y,     w_cmd_y_nxt;
  logic [VAL_W-1:0]      r_cmd_num,   w_cmd_num_nxt;
  logic                  r_deny,      w_deny_nxt;
  logic [FLASH_BITS-1:0] r_flash_cnt, w_flash_cnt_nxt;

  logic w_cell_val_ok;

  assign w_cell_val_ok = (i_cell_val != '0) && (i_cell_val <= VAL_LAST);

  // ---------------------------------------------------------------------------
  // Mode FSM; if/else chains below encode the C > U > D > L > R priority and
  // drop any lower-priority pulse that arrives in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cursor_x_nxt  = r_cursor_x;
    w_cursor_y_nxt  = r_cursor_y;
    w_mode_nxt      = r_mode;
    w_sel_nxt       = r_sel;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_x_nxt     = r_cmd_x;
    w_cmd_y_nxt     = r_cmd_y;
    w_cmd_num_nxt   = r_cmd_num;
    w_deny_nxt      = 1'b0;
    w_flash_cnt_nxt = r_flash_cnt + 1'b1;

    if (i_puzzle_change) begin
      w_cursor_x_nxt  = '0;
      w_cursor_y_nxt  = '0;
      w_mode_nxt      = MODE_MOVE;
      w_sel_nxt       = VAL_ONE;
      w_cmd_valid_nxt = 1'b0;
      w_cmd_x_nxt     = '0;
      w_cmd_y_nxt     = '0;
      w_cmd_num_nxt   = '0;
      w_flash_cnt_nxt = '0;
    end else begin
      case (r_mode)
        MODE_MOVE: begin
          if (w_key_pulse[KEY_C]) begin
            if (i_cell_fixed) begin
              w_deny_nxt = 1'b1;
            end else begin
              w_mode_nxt = MODE_NUMBER;
              w_sel_nxt  = w_cell_val_ok ? i_cell_val : VAL_ONE;
            end
          end else if (w_key_pulse[KEY_U]) begin
            w_cursor_y_nxt = coord_dec(r_cursor_y);
          end else if (w_key_pulse[KEY_D]) begin
            w_cursor_y_nxt = coord_inc(r_cursor_y);
          end else if (w_key_pulse[KEY_L]) begin
            w_cursor_x_nxt = coord_dec(r_cursor_x);
          end else if (w_key_pulse[KEY_R]) begin
            w_cursor_x_nxt = coord_inc(r_cursor_x);
          end
        end

        MODE_NUMBER: begin
          if (w_key_pulse[KEY_C]) begin
            w_mode_nxt      = MODE_ISSUE;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_x_nxt     = r_cursor_x;
            w_cmd_y_nxt     = r_cursor_y;
            w_cmd_num_nxt   = r_sel;
          end else if (w_key_pulse[KEY_U]) begin
            w_sel_nxt = val_inc(r_sel);
          end else if (w_key_pulse[KEY_D]) begin
            w_sel_nxt = val_dec(r_sel);
          end else if (w_key_pulse[KEY_L]) begin
            w_mode_nxt      = MODE_ISSUE;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_x_nxt     = r_cursor_x;
            w_cmd_y_nxt     = r_cursor_y;
            w_cmd_num_nxt   = '0;
          end else if (w_key_pulse[KEY_R]) begin
            w_mode_nxt = MODE_MOVE;
          end
        end

        MODE_ISSUE: begin
          // Keys are ignored; wait indefinitely for the engine.
          if (i_cmd_ready) begin
            w_mode_nxt      = MODE_MOVE;
            w_cmd_valid_nxt = 1'b0;
          end
        end

        default: begin
          w_mode_nxt      = MODE_MOVE;
          w_cmd_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cursor_x  <= '0;
      r_cursor_y  <= '0;
      r_mode      <= MODE_MOVE;
      r_sel       <= VAL_ONE;
      r_cmd_valid <= 1'b0;
      r_cmd_x     <= '0;
      r_cmd_y     <= '0;
      r_cmd_num   <= '0;
      r_deny      <= 1'b0;
      r_flash_cnt <= '0;
    end else begin
      r_cursor_x  <= w_cursor_x_nxt;
      r_cursor_y  <= w_cursor_y_nxt;
      r_mode      <= w_mode_nxt;
      r_sel       <= w_sel_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_x     <= w_cmd_x_nxt;
      r_cmd_y     <= w_cmd_y_nxt;
      r_cmd_num   <= w_cmd_num_nxt;
      r_deny      <= w_deny_nxt;
      r_flash_cnt <= w_flash_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cursor_x        = r_cursor_x;
  assign o_cursor_y        = r_cursor_y;
  assign o_mode            = r_mode;
  assign o_selected_number = r_sel;
  assign o_cmd_valid       = r_cmd_valid;
  assign o_cmd_x           = r_cmd_x;
  assign o_cmd_y           = r_cmd_y;
  assign o_cmd_number      = r_cmd_num;
  assign o_fixed_deny      = r_deny;
  // Cursor blinks only while a number is being chosen or committed.
  assign o_flash = ((r_mode == MODE_NUMBER) || (r_mode == MODE_ISSUE)) ?
                   r_flash_cnt[FLASH_BITS-1] : 1'b1;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// Directed bench for sudoku_input_ctrl with a command scoreboard.
module tb_sudoku_input_ctrl;
  import sudoku_pkg::*;

  localparam int unsigned GRID_N  = 9;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned VAL_W   = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [VAL_W-1:0]   n;
  } cmd_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               puzzle_change = 1'b0;
  logic               key_u = 1'b0, key_d = 1'b0, key_l = 1'b0, key_r = 1'b0, key_c = 1'b0;
  logic               cell_fixed = 1'b0;
  logic [VAL_W-1:0]   cell_val = '0;
  logic               cmd_ready = 1'b0;
  logic [COORD_W-1:0] cursor_x, cursor_y, cmd_x, cmd_y;
  mode_t              mode;
  logic [VAL_W-1:0]   selected_number, cmd_number;
  logic               cmd_valid, fixed_deny, flash;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   tb_cnt   = 0;
  cmd_t exp_q[$];

  always #5 clk = ~clk;

  sudoku_input_ctrl #(
    .GRID_N       (GRID_N),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (4),
    .FLASH_BITS   (4)
  ) dut (
    .i_clk             (clk),
    .i_reset_n         (reset_n),
    .i_puzzle_change   (puzzle_change),
    .i_key_u           (key_u),
    .i_key_d           (key_d),
    .i_key_l           (key_l),
    .i_key_r           (key_r),
    .i_key_c           (key_c),
    .i_cell_fixed      (cell_fixed),
    .i_cell_val        (cell_val),
    .i_cmd_ready       (cmd_ready),
    .o_cursor_x        (cursor_x),
    .o_cursor_y        (cursor_y),
    .o_mode            (mode),
    .o_selected_number (selected_number),
    .o_cmd_valid       (cmd_valid),
    .o_cmd_x           (cmd_x),
    .o_cmd_y           (cmd_y),
    .o_cmd_number      (cmd_number),
    .o_fixed_deny      (fixed_deny),
    .o_flash           (flash)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; model the free-running flash counter alongside.
  task automatic tick();
    @(posedge clk);
    if (!reset_n || puzzle_change) tb_cnt = 0;
    else tb_cnt++;
    #1;
  endtask

  task automatic set_keys(input logic [4:0] v);
    key_c = v[KEY_C];
    key_u = v[KEY_U];
    key_d = v[KEY_D];
    key_l = v[KEY_L];
    key_r = v[KEY_R];
  endtask

  // Level high for one sample, then wait for the FSM edge.
  task automatic press(input logic [4:0] v);
    set_keys(v);
    tick();
    set_keys(5'b0);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},     32'(cursor_x), 0);
    check({tag, "_y"},     32'(cursor_y), 0);
    check({tag, "_mode"},  32'(mode), 32'(MODE_MOVE));
    check({tag, "_sel"},   32'(selected_number), 1);
    check({tag, "_valid"}, 32'(cmd_valid), 0);
    check({tag, "_cx"},    32'(cmd_x), 0);
    check({tag, "_cy"},    32'(cmd_y), 0);
    check({tag, "_cn"},    32'(cmd_number), 0);
    check({tag, "_deny"},  32'(fixed_deny), 0);
    check({tag, "_flash"}, 32'(flash), 1);
  endtask

  // Hold ready low for wait_cycles, then complete the handshake and score it.
  task automatic handshake(input int wait_cycles);
    cmd_t got;
    cmd_t exp;
    for (int i = 0; i < wait_cycles; i++) begin
      check("valid_wait", 32'(cmd_valid), 1);
      check("mode_wait", 32'(mode), 32'(MODE_ISSUE));
      tick();
    end
    check("valid_pre_ready", 32'(cmd_valid), 1);
    got = '{x: cmd_x, y: cmd_y, n: cmd_number};
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("sb_nonempty", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("sb_cmd_x", 32'(got.x), 32'(exp.x));
      check("sb_cmd_y", 32'(got.y), 32'(exp.y));
      check("sb_cmd_n", 32'(got.n), 32'(exp.n));
    end
    check("valid_post_ready", 32'(cmd_valid), 0);
    check("mode_post_ready", 32'(mode), 32'(MODE_MOVE));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_y;

    // Reset
    #1 reset_n = 1'b0;
    #2 check_reset_vals("reset");
    tick();
    tick();
    reset_n = 1'b1;
    tb_cnt  = 0;

    // Single U at (0,0) wraps to the bottom row
    press(5'b1 << KEY_U);
    check("u_wrap_y", 32'(cursor_y), 8);
    press(5'b1 << KEY_R);
    check("r_first_x", 32'(cursor_x), 1);
    for (int i = 1; i < 9; i++) press(5'b1 << KEY_R);
    check("r_wrap_x", 32'(cursor_x), 0);
    press(5'b1 << KEY_D);
    check("d_wrap_y", 32'(cursor_y), 0);

    // D held 20 samples: pulses at E0, E0+8, E0+12, E0+16
    key_d = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_y = int'(i >= 2) + int'(i >= 10) + int'(i >= 14) + int'(i >= 18);
      check("d_hold_y", 32'(cursor_y), 32'(exp_y));
    end
    key_d = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("d_hold_final_y", 32'(cursor_y), 4);

    // Enter NUMBER with an existing value, wrap 9 -> 1
    cell_fixed = 1'b0;
    cell_val   = 4'd7;
    press(5'b1 << KEY_C);
    check("num_mode", 32'(mode), 32'(MODE_NUMBER));
    check("num_sel7", 32'(selected_number), 7);
    press(5'b1 << KEY_U);
    check("num_sel8", 32'(selected_number), 8);
    press(5'b1 << KEY_U);
    check("num_sel9", 32'(selected_number), 9);
    press(5'b1 << KEY_U);
    check("num_sel_wrap1", 32'(selected_number), 1);
    for (int i = 0; i < 16; i++) begin
      check("num_flash", 32'(flash), 32'((tb_cnt >> 3) & 1));
      tick();
    end

    // Commit, keys ignored while issuing, ready delayed by 5 cycles
    press(5'b1 << KEY_C);
    exp_q.push_back('{x: 4'd0, y: 4'd4, n: 4'd1});
    check("issue_mode", 32'(mode), 32'(MODE_ISSUE));
    check("issue_valid", 32'(cmd_valid), 1);
    check("issue_num", 32'(cmd_number), 1);
    press(5'b1 << KEY_U);
    check("issue_ignore_y", 32'(cursor_y), 4);
    check("issue_ignore_sel", 32'(selected_number), 1);
    check("issue_flash", 32'(flash), 32'((tb_cnt >> 3) & 1));
    handshake(5);

    // Fixed cell: deny pulse lasts exactly one cycle
    cell_fixed = 1'b1;
    press(5'b1 << KEY_C);
    check("deny_mode", 32'(mode), 32'(MODE_MOVE));
    check("deny_hi", 32'(fixed_deny), 1);
    tick();
    check("deny_lo", 32'(fixed_deny), 0);
    cell_fixed = 1'b0;

    // Out-of-range cell value defaults to 1, D wraps 1 -> 9, L clears
    cell_val = 4'd12;
    press(5'b1 << KEY_C);
    check("oor_sel", 32'(selected_number), 1);
    press(5'b1 << KEY_D);
    check("num_dec_wrap", 32'(selected_number), 9);
    press(5'b1 << KEY_L);
    exp_q.push_back('{x: 4'd0, y: 4'd4, n: 4'd0});
    check("clear_valid", 32'(cmd_valid), 1);
    check("clear_num", 32'(cmd_number), 0);
    handshake(0);

    // R cancels with no command
    cell_val = 4'd0;
    press(5'b1 << KEY_C);
    check("empty_sel", 32'(selected_number), 1);
    press(5'b1 << KEY_R);
    check("cancel_mode", 32'(mode), 32'(MODE_MOVE));
    for (int i = 0; i < 3; i++) begin
      check("cancel_no_valid", 32'(cmd_valid), 0);
      tick();
    end

    // puzzle_change abandons an issue in progress
    press(5'b1 << KEY_R);
    cell_val = 4'd3;
    press(5'b1 << KEY_C);
    check("pc_sel3", 32'(selected_number), 3);
    press(5'b1 << KEY_C);
    check("pc_issue_valid", 32'(cmd_valid), 1);
    check("pc_issue_x", 32'(cmd_x), 1);
    puzzle_change = 1'b1;
    tick();
    puzzle_change = 1'b0;
    check_reset_vals("puzzle");

    // Asynchronous reset in the middle of an L repeat
    press(5'b1 << KEY_D);
    check("pre_rst_y", 32'(cursor_y), 1);
    key_l = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("repeat_l_x", 32'(cursor_x), 7);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    key_l = 1'b0;
    tick();
    reset_n = 1'b1;
    tb_cnt  = 0;
    tick();
    tick();
    check("post_rst_x", 32'(cursor_x), 0);

    // C and U in the same cycle: C wins, U dropped
    cell_val = 4'd5;
    press((5'b1 << KEY_C) | (5'b1 << KEY_U));
    check("prio_mode", 32'(mode), 32'(MODE_NUMBER));
    check("prio_sel", 32'(selected_number), 5);
    check("prio_y", 32'(cursor_y), 0);
    press(5'b1 << KEY_R);
    check("prio_cancel_mode", 32'(mode), 32'(MODE_MOVE));
    check("prio_y_after", 32'(cursor_y), 0);

    check("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sudoku_input_ctrl.md
Name: sudoku_input_ctrl

Overview:
- Parametrised cursor/number-entry controller for an N×N Sudoku grid (N = 4, 9 or 16).
- Takes debounced button levels and does its own edge detection and auto-repeat.
- Owns the cursor position and the MOVE/NUMBER mode FSM.
- Issues cell writes and clears to the sudoku engine over a valid/ready handshake, and drives the flash signal for the draw module.

Parameters:
- GRID_N, 9, grid side length; legal range 2..16.
- COORD_W, $clog2(GRID_N), cursor coordinate width (derived; do not override).
- VAL_W, $clog2(GRID_N+1), cell value width (derived; 9 -> 4).
- REPEAT_DELAY, 50_000_000, cycles a held key waits before the first repeat pulse.
- REPEAT_RATE, 15_000_000, cycles between subsequent repeat pulses.
- FLASH_BITS, 27, flash counter width; the flash output toggles at the MSB.

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- puzzle_change  in  1  synchronous soft reset pulse, asserted when puzzle selection changes
- key_u, key_d, key_l, key_r, key_c  in  1 each  debounced button levels
- cell_fixed  in  1  fixed-mask bit of the cell at (cursor_x, cursor_y)
- cell_val  in  VAL_W  current value of the cursor cell (0 = empty)
- cmd_ready  in  1  engine accepts the command this cycle
- cursor_x, cursor_y  out  COORD_W each  cursor position
- mode  out  2  sudoku_pkg::mode_t
- selected_number  out  VAL_W  number being previewed
- cmd_valid  out  1  write command pending
- cmd_x, cmd_y  out  COORD_W each  target cell of the command
- cmd_number  out  VAL_W  value to write (0 = clear)
- fixed_deny  out  1  one-cycle pulse when C is pressed on a fixed cell
- flash  out  1  cursor visibility for the draw module

Behaviour:
Reset:
- Asynchronous on reset_n low.
- Reset values: cursor 0,0; mode MODE_MOVE; selected_number 1; cmd_valid 0; cmd_x/cmd_y/cmd_number 0; fixed_deny 0; flash 1; flash counter 0.
- puzzle_change has the same effect synchronously. It takes priority over all keys and abandons MODE_ISSUE without a handshake; cmd_valid is low on the next cycle.

Key pulses:
- Each key's level is registered once.
- Pulse is asserted for 1 cycle on the edge E0 where the level is first sampled high.
- U/D/L/R only: while held, further pulses at E0+REPEAT_DELAY, then every REPEAT_RATE cycles.
- C never repeats.
- Release clears the repeat counter.
- The FSM acts on a pulse at the next edge, so outputs change at E0+1.

Arbitration:
- One action per cycle, priority C > U > D > L > R.
- Lower-priority pulses in the same cycle are dropped, not queued.

MODE_MOVE:
- U: cursor_y -= 1, wrapping 0 -> GRID_N-1.
- D: cursor_y += 1, wrapping GRID_N-1 -> 0.
- L/R: same rules on cursor_x.
- C with cell_fixed=0: go to MODE_NUMBER; selected_number = cell_val if 1..GRID_N, otherwise 1.
- C with cell_fixed=1: stay in MODE_MOVE and pulse fixed_deny.

MODE_NUMBER:
- U: selected_number += 1, wrapping GRID_N -> 1.
- D: selected_number -= 1, wrapping 1 -> GRID_N.
- C: latch cmd_x/cmd_y = cursor and cmd_number = selected_number; go to MODE_ISSUE.
- L: latch cursor with cmd_number = 0 (clear); go to MODE_ISSUE.
- R: cancel and return to MODE_MOVE with no command.

MODE_ISSUE:
- cmd_valid = 1; cmd_x, cmd_y and cmd_number are held stable.
- All key pulses are ignored.
- When cmd_ready is sampled high: cmd_valid goes 0 and mode goes to MODE_MOVE on that edge.
- No timeout.
- cmd_ready while not in MODE_ISSUE is ignored.

Flash:
- The free-running counter increments every cycle.
- flash = counter MSB in MODE_NUMBER and MODE_ISSUE, otherwise 1.

Decomposition:
- Shared package sudoku_pkg holds:
  - typedef mode_t {MODE_MOVE=0, MODE_NUMBER=1, MODE_ISSUE=2};
  - key-index constants KEY_C..KEY_R in priority order.
- Sub-module key_repeat, parameters REPEAT_DELAY and REPEAT_RATE, ports clk, reset_n, clr, level, pulse. Instantiated once per key; the C instance uses repeat disabled (REPEAT_DELAY=0 meaning no repeat).

Test Plan (GRID_N=9, REPEAT_DELAY=8, REPEAT_RATE=4, FLASH_BITS=4):
- Reset, then key_u held 1 cycle at cursor (0,0) -> cursor_y=8 one edge after the pulse; key_r ×9 -> cursor_x returns to 0.
- key_d held 20 cycles -> exactly 4 pulses (at E0, E0+8, E0+12, E0+16); cursor_y advances 0->4.
- cell_fixed=0, cell_val=7, press C -> mode=NUMBER, selected_number=7; U,U,U -> 1 (wrap 9->1); C -> cmd_valid=1, cmd_number=1; cmd_ready low 5 cycles then high -> cmd_valid stays high through the wait and drops on the ready edge; mode=MOVE.
- cell_fixed=1, press C -> mode stays MOVE, fixed_deny high exactly 1 cycle; in NUMBER, L -> cmd_number=0 issued; R instead -> MOVE with no cmd_valid.
- In MODE_ISSUE, assert puzzle_change -> next cycle cmd_valid=0, cursor 0,0, selected_number=1; reset_n low mid-repeat -> all outputs at reset values immediately (asynchronously).
- key_c and key_u pulse in the same cycle in MOVE -> C acts (mode=NUMBER), U dropped (cursor unchanged).
